// File: rtl/rtc_cmd_ctrl.sv
// rtc_cmd_ctrl: range-checks and packs host commands, queues them, issues them one at a time to the RTC and latches the alarm interrupt
module rtc_cmd_ctrl #(
    parameter int FIFO_DEPTH = 4,
    parameter int RD_LAT     = 1
) (
    input  logic        clk,
    input  logic        resetn,
    input  logic        cmd_valid,
    output logic        cmd_ready,
    input  logic [1:0]  cmd_op,
    input  logic        cmd_add,
    input  logic [5:0]  cmd_sec,
    input  logic [5:0]  cmd_min,
    input  logic [4:0]  cmd_hr,
    input  logic [8:0]  cmd_day,
    input  logic [5:0]  cmd_yr,
    output logic        cmd_err,
    output logic        rsp_valid,
    input  logic        rsp_ready,
    output logic [31:0] rsp_data,
    output logic        rtc_on,
    output logic [1:0]  rtc_op,
    output logic [31:0] rtc_w_data,
    input  logic [31:0] rtc_r_data,
    input  logic        rtc_alarm,
    input  logic        irq_clr,
    output logic        alarm_irq
);
    localparam int AW = $clog2(FIFO_DEPTH);
    localparam int CW = (RD_LAT > 1) ? $clog2(RD_LAT) : 1;

    typedef enum logic [2:0] {ST_IDLE, ST_ISSUE, ST_WAIT, ST_RESP, ST_GAP} state_t;

    state_t          state;
    logic [CW-1:0]   wait_cnt;
    logic            ready_en;
    logic [AW-1:0]   wr_ptr;
    logic [AW-1:0]   rd_ptr;
    logic [AW:0]     count;
    logic [33:0]     mem [FIFO_DEPTH];
    logic [33:0]     head;
    logic [31:0]     word;
    logic            full;
    logic            accept;
    logic            bad;
    logic            push;
    logic            pop;
    logic            alarm_q;

    assign full      = count == (AW + 1)'(FIFO_DEPTH);
    assign cmd_ready = ready_en & ~full;
    assign accept    = cmd_valid & cmd_ready;
    assign bad       = (cmd_op != 2'b00) &
                       ((cmd_sec > 6'd59) | (cmd_min > 6'd59) | (cmd_hr > 5'd23) | (cmd_day > 9'd365));
    assign push      = accept & ~bad;
    assign pop       = (state == ST_IDLE) && (count != '0);
    assign head      = mem[rd_ptr];

    // Pack the host fields into the RTC word layout for the requested operation
    always_comb begin
        word = (cmd_op == 2'b01) ? {cmd_sec, cmd_min, cmd_hr, cmd_day, cmd_yr} :
               (cmd_op == 2'b10) ? {cmd_sec, cmd_min, cmd_hr, 1'b1, 14'b0} :
               (cmd_op == 2'b11) ? {cmd_sec, cmd_min, cmd_hr, cmd_day, cmd_add, 5'b0} : 32'b0;
    end

    // Command FIFO storage; contents are don't-care until written
    always_ff @(posedge clk) begin
        if (push) mem[wr_ptr] <= {cmd_op, word};
    end

    // FIFO pointers, occupancy, post-reset ready enable and the range-error pulse
    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) begin
            wr_ptr   <= '0;
            rd_ptr   <= '0;
            count    <= '0;
            ready_en <= 1'b0;
            cmd_err  <= 1'b0;
        end else begin
            ready_en <= 1'b1;
            cmd_err  <= accept & bad;
            if (push) wr_ptr <= wr_ptr + 1'b1;
            if (pop) rd_ptr <= rd_ptr + 1'b1;
            if (push & ~pop) count <= count + 1'b1;
            else if (pop & ~push) count <= count - 1'b1;
        end
    end

    // Issue sequencer: one strobe per command, read capture and response hold, then a guard cycle
    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) begin
            state      <= ST_IDLE;
            wait_cnt   <= '0;
            rtc_on     <= 1'b0;
            rtc_op     <= 2'b00;
            rtc_w_data <= 32'b0;
            rsp_valid  <= 1'b0;
            rsp_data   <= 32'b0;
        end else begin
            case (state)
                ST_IDLE: begin
                    if (pop) begin
                        state      <= ST_ISSUE;
                        rtc_on     <= 1'b1;
                        rtc_op     <= head[33:32];
                        rtc_w_data <= head[31:0];
                    end
                end
                ST_ISSUE: begin
                    rtc_on   <= 1'b0;
                    wait_cnt <= '0;
                    if (rtc_op != 2'b00) begin
                        state <= ST_GAP;
                    end else if (RD_LAT == 1) begin
                        rsp_data  <= rtc_r_data;
                        rsp_valid <= 1'b1;
                        state     <= ST_RESP;
                    end else begin
                        state <= ST_WAIT;
                    end
                end
                ST_WAIT: begin
                    if (wait_cnt == CW'(RD_LAT - 2)) begin
                        rsp_data  <= rtc_r_data;
                        rsp_valid <= 1'b1;
                        state     <= ST_RESP;
                    end else begin
                        wait_cnt <= wait_cnt + 1'b1;
                    end
                end
                ST_RESP: begin
                    if (rsp_ready) begin
                        rsp_valid <= 1'b0;
                        state     <= ST_GAP;
                    end
                end
                ST_GAP:  state <= ST_IDLE;
                default: state <= ST_IDLE;
            endcase
        end
    end

    // Sticky alarm interrupt on the rising edge of rtc_alarm; a new edge beats a clear
    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) begin
            alarm_q   <= 1'b0;
            alarm_irq <= 1'b0;
        end else begin
            alarm_q   <= rtc_alarm;
            alarm_irq <= (rtc_alarm & ~alarm_q) | (alarm_irq & ~irq_clr);
        end
    end
endmodule
